// File: rtl/uart_rx_pkg.sv
// Package: uart_rx_pkg
// Shared types, default sizes and helper for the UART Rx frame buffer.
//   rx_entry_t    : default-width queued frame layout {data, trans_err, data_err}.
//                   Modules build the same field order at their own DATA_SIZE.
//   DATA_SIZE_DEF : default data bits per frame
//   DEPTH_DEF     : default FIFO depth
//   ptr_w()       : FIFO pointer width (index bits plus one wrap bit)
package uart_rx_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int DEPTH_DEF     = 8;

  typedef struct packed {
    logic [DATA_SIZE_DEF-1:0] data;
    logic                     trans_err;
    logic                     data_err;
  } rx_entry_t;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Module: uart_rx_fifo_mem
// DEPTH x W register array holding queued frames.
// Synchronous write, asynchronous (combinational) read so the head entry
// falls straight through to the consumer outputs. Contents are never reset.
// Ports:
//   clk      : clock, rising edge
//   we_i     : write enable
//   waddr_i  : write index
//   wdata_i  : entry to store
//   raddr_i  : read index
//   rdata_o  : entry at raddr_i
module uart_rx_fifo_mem
  import uart_rx_pkg::*;
#(
  parameter int W     = DATA_SIZE_DEF + 2,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];

  // One write-decoded register per slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (we_i && (waddr_i == AW'(gi))) begin
        mem_q[gi] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_frame_buffer.sv
// Module: uart_rx_frame_buffer
// Captures each completed UART Rx frame on the rising edge of frame_done and
// queues it in a first-word-fall-through FIFO presented over valid/ready.
// Ports:
//   clk, rst (async active-low)
//   frame_done, rx_data, trans_err, data_err : frame from the Rx datapath
//   m_valid, m_ready, m_data, m_trans_err, m_data_err : consumer interface
//   count    : entries stored
//   overflow : sticky, a frame was lost while full; cleared by ovf_clr
//   drop_cnt : (UART_RX_ERR_DROP_EN only) saturating count of errored
//              frames discarded; cleared by ovf_clr
// Configuration macro: UART_RX_ERR_DROP_EN -- discard errored frames instead
// of queueing them; error outputs are then tied low.
module uart_rx_frame_buffer
  import uart_rx_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter bit PARITY_ON = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_done,
  input  logic [DATA_SIZE-1:0]   rx_data,
  input  logic                   trans_err,
  input  logic                   data_err,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_SIZE-1:0]   m_data,
  output logic                   m_trans_err,
  output logic                   m_data_err,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   ovf_clr
`ifdef UART_RX_ERR_DROP_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int EW = DATA_SIZE + 2;

  logic          frame_done_q;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic          push_edge, push_req, pop, full, do_push, ovf_set;
  logic [EW-1:0] wr_entry, rd_entry;

  // One push per frame no matter how long frame_done is held.
  assign push_edge = frame_done & ~frame_done_q;

`ifdef UART_RX_ERR_DROP_EN
  logic       frame_bad;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign frame_bad = trans_err | (PARITY_ON & data_err);
  assign push_req  = push_edge & ~frame_bad;
`else
  assign push_req  = push_edge;
`endif

  assign count   = wr_ptr_q - rd_ptr_q;
  assign m_valid = (count != '0);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop     = m_valid & m_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;

  assign wr_entry = {rx_data, trans_err, (PARITY_ON & data_err)};

  uart_rx_fifo_mem #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (do_push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_entry)
  );

  assign m_data   = rd_entry[EW-1:2];
  assign overflow = overflow_q;

`ifdef UART_RX_ERR_DROP_EN
  assign m_trans_err = 1'b0;
  assign m_data_err  = 1'b0;
  assign drop_cnt    = drop_cnt_q;
`else
  assign m_trans_err = rd_entry[1];
  assign m_data_err  = rd_entry[0];
`endif

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    // A new loss outranks a clear in the same cycle.
    if (ovf_set)      overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

`ifdef UART_RX_ERR_DROP_EN
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (push_edge && frame_bad) begin
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (ovf_clr) begin
      drop_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= 8'd0;
    else      drop_cnt_q <= drop_cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= frame_done;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule
